audio_tone_dac: RTL and testbench

Tone generator and serial DAC driver that consumes the keyboard-to-note decoder's output: a 16-bit tone word plus an active-low mute flag. It runs a phase accumulator once per audio frame and converts the tone word into a square wave. It then streams that wave as a left-justified serial frame (BCLK/LRCK/DATA) to the board's audio codec, sending the same sample on both channels.

---
 rtl/audio_tone_dac.sv | 119 +++++++++++
 tb/tb_audio_tone_dac.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_dac.sv
// Square-wave tone generator streaming left-justified 16-bit frames (same sample on both channels).
// Latency: sound/sound_off are sampled only at frame start; the new sample's MSB appears that same cycle.
// Backpressure: none; free-running serial stream. Optional envelope ramp: AUDIO_TONE_DAC_RAMP_EN.
module audio_tone_dac #(
    parameter int          BCLK_HALF = 6,
    parameter int          PHASE_W   = 24,
    parameter logic [15:0] AMP       = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sound,
    input  logic        sound_off,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        sample_tick
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [4:0]         bit_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_next;
    logic [15:0]        sample;
    logic [15:0]        sample_next;
    logic [15:0]        shreg;
    logic [15:0]        mag;
    logic               div_wrap;
    logic               fall_evt;
    logic               frame_start;
    logic               play;

    assign div_wrap    = (div_cnt == DIV_MAX);
    assign fall_evt    = div_wrap & aud_bclk;
    assign frame_start = fall_evt & (bit_cnt == 5'd31);
    assign play        = sound_off & (sound > 16'd1);
    assign aud_daclrck = ~bit_cnt[4];
    assign aud_dacdat  = shreg[15];

`ifdef AUDIO_TONE_DAC_RAMP_EN
    logic [4:0]  env;
    logic [4:0]  env_next;
    logic [19:0] mag_acc;

    // Envelope step for this frame and magnitude AMP*env/16 by shift-and-add.
    always_comb begin
        env_next = env;
        if (play) begin
            if (env != 5'd16) env_next = env + 5'd1;
        end else if (env != 5'd0) begin
            env_next = env - 5'd1;
        end
        mag_acc = '0;
        for (int i = 0; i < 5; i++) begin
            if (env_next[i]) mag_acc = mag_acc + (20'(AMP) << i);
        end
        mag = mag_acc[19:4];
    end

    // Envelope register advances once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env <= 5'd0;
        end else if (frame_start) begin
            env <= env_next;
        end
    end
`else
    // Magnitude switches hard between silence and full amplitude.
    assign mag = play ? AMP : 16'd0;
`endif

    // Phase step and the signed square-wave sample for the upcoming frame.
    always_comb begin
        phase_next = phase;
        if (play) phase_next = phase + {{(PHASE_W-16){1'b0}}, sound};
        sample_next = phase_next[PHASE_W-1] ? (16'd0 - mag) : mag;
    end

    // Bit-clock divider: toggle aud_bclk every BCLK_HALF clk cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            aud_bclk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            aud_bclk <= ~aud_bclk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // Bit counter, phase/sample update and serializer, all on fall events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 5'd31;
            phase       <= '0;
            sample      <= 16'd0;
            shreg       <= 16'd0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= frame_start;
            if (frame_start) begin
                bit_cnt <= 5'd0;
                phase   <= phase_next;
                sample  <= sample_next;
                shreg   <= sample_next;
            end else if (fall_evt) begin
                bit_cnt <= bit_cnt + 5'd1;
                // Entering bit 16: right channel repeats the left sample.
                if (bit_cnt == 5'd15) shreg <= sample;
                else                  shreg <= {shreg[14:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_audio_tone_dac.sv
`timescale 1ns/1ps
// Scoreboard bench for audio_tone_dac: stimulus tasks push expected frame words, a monitor
// deserializes the DAC stream on bit-clock rises and pops/compares them.
// Runs with BCLK_HALF=2 (128 clk per frame) and a 17-bit phase accumulator.
module tb_audio_tone_dac;

    localparam int          BH  = 2;
    localparam int          PW  = 17;
    localparam logic [15:0] AMP = 16'h2000;
    localparam int          FRAME = 64 * BH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] sound = 16'd0;
    logic        sound_off = 1'b1;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        sample_tick;

    int checks = 0;
    int errors = 0;

    logic [15:0]   exp_q[$];
    logic [PW-1:0] phase_m;
`ifdef AUDIO_TONE_DAC_RAMP_EN
    int env_m;
`endif

    audio_tone_dac #(.BCLK_HALF(BH), .PHASE_W(PW), .AMP(AMP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sound       (sound),
        .sound_off   (sound_off),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    // Reference model: one frame start with the given inputs; both channel words queued.
    task automatic push_frame(input logic [15:0] snd, input logic off);
        logic        play;
        logic [15:0] m;
        logic [15:0] w;
        play = off && (snd > 16'd1);
        if (play) phase_m = phase_m + PW'(snd);
`ifdef AUDIO_TONE_DAC_RAMP_EN
        if (play && env_m < 16) env_m++;
        else if (!play && env_m > 0) env_m--;
        m = 16'((32'(AMP) * env_m) / 16);
`else
        m = play ? AMP : 16'd0;
`endif
        w = phase_m[PW-1] ? (16'd0 - m) : m;
        exp_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic model_reset();
        exp_q.delete();
        phase_m = '0;
`ifdef AUDIO_TONE_DAC_RAMP_EN
        env_m = 0;
`endif
    endtask

    task automatic drive_push(input logic [15:0] snd, input logic off);
        sound     = snd;
        sound_off = off;
        push_frame(snd, off);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 400);
        checks++;
        if (!sample_tick) begin
            errors++;
            $display("FAIL tick_timeout: no sample_tick after %0d clk", n);
        end
    endtask

    task automatic step(input logic [15:0] snd, input logic off);
        int n;
        drive_push(snd, off);
        wait_tick(n);
        checks++;
        if (n !== FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d clk, expected %0d", n, FRAME);
        end
    endtask

    // Monitor: capture bits on bclk rises, check channel clock, compare words; check output stability.
    logic        prev_bclk = 1'b0;
    logic        prev_dat = 1'b0;
    logic        prev_lr = 1'b0;
    logic        mon_act = 1'b0;
    int          bit_idx = 0;
    logic [15:0] word = 16'd0;
    logic [15:0] exp_w;
    logic        exp_lr;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
            bit_idx = 0;
        end else begin
            if (sample_tick) begin
                mon_act = 1'b1;
                bit_idx = 0;
            end
            if (aud_bclk && !prev_bclk && mon_act) begin
                word   = {word[14:0], aud_dacdat};
                exp_lr = (bit_idx < 16);
                checks++;
                if (aud_daclrck !== exp_lr) begin
                    errors++;
                    $display("FAIL lrck_bit%0d: got %b expected %b", bit_idx, aud_daclrck, exp_lr);
                end
                if (bit_idx == 15 || bit_idx == 31) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL word_underflow: got %h, expected nothing queued", word);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (word !== exp_w) begin
                            errors++;
                            $display("FAIL word_%s: got %h expected %h",
                                     (bit_idx == 15) ? "left" : "right", word, exp_w);
                        end
                    end
                end
                bit_idx++;
                if (bit_idx == 32) mon_act = 1'b0;
            end
            if ((aud_dacdat !== prev_dat || aud_daclrck !== prev_lr) && !(prev_bclk && !aud_bclk)) begin
                checks++;
                errors++;
                $display("FAIL stability: dat/lrck changed to %b/%b outside a fall event",
                         aud_dacdat, aud_daclrck);
            end
        end
        prev_bclk = aud_bclk;
        prev_dat  = aud_dacdat;
        prev_lr   = aud_daclrck;
    end

    task automatic test_reset();
        int n;
        sound     = 16'd0;
        sound_off = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({aud_bclk, aud_daclrck, aud_dacdat, sample_tick} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 0000",
                         {aud_bclk, aud_daclrck, aud_dacdat, sample_tick});
            end
        end
        model_reset();
        push_frame(16'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!aud_bclk && n < 20);
        checks++;
        if (n !== BH) begin
            errors++;
            $display("FAIL first_rise: got %0d clk expected %0d", n, BH);
        end
        @(negedge clk);
        checks++;
        if (aud_daclrck !== 1'b0 || sample_tick !== 1'b0) begin
            errors++;
            $display("FAIL pre_frame: lrck/tick got %b/%b expected 0/0", aud_daclrck, sample_tick);
        end
        @(negedge clk);
        checks++;
        if ({aud_bclk, aud_daclrck, sample_tick} !== 3'b011) begin
            errors++;
            $display("FAIL first_frame: bclk/lrck/tick got %b expected 011",
                     {aud_bclk, aud_daclrck, sample_tick});
        end
    endtask

    task automatic test_frame_shape();
        int hi;
        int n;
        drive_push(16'd0, 1'b1);
        hi = int'(aud_daclrck);
        for (int i = 0; i < FRAME - 1; i++) begin
            @(negedge clk);
            hi += int'(aud_daclrck);
        end
        wait_tick(n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL shape_period: tick came %0d clk late, expected 1", n);
        end
        checks++;
        if (hi !== FRAME / 2) begin
            errors++;
            $display("FAIL shape_lrck_high: got %0d clk expected %0d", hi, FRAME / 2);
        end
        step(16'd0, 1'b1);
    endtask

    task automatic test_square_wave();
        for (int i = 0; i < 6; i++) step(16'hFFFF, 1'b1);
    endtask

    task automatic test_mid_frame();
        int n;
        repeat (5 * 2 * BH) @(negedge clk);
        drive_push(16'd1, 1'b1);
        wait_tick(n);
        checks++;
        if (n !== FRAME - 10 * BH) begin
            errors++;
            $display("FAIL mid_period: got %0d clk expected %0d", n, FRAME - 10 * BH);
        end
        // A glitch that reverts before the frame start must not affect anything.
        drive_push(16'hFFFF, 1'b1);
        repeat (20) @(negedge clk);
        sound     = 16'd0;
        sound_off = 1'b0;
        repeat (20) @(negedge clk);
        sound     = 16'hFFFF;
        sound_off = 1'b1;
        wait_tick(n);
        checks++;
        if (n !== FRAME - 40) begin
            errors++;
            $display("FAIL glitch_period: got %0d clk expected %0d", n, FRAME - 40);
        end
    endtask

    task automatic test_mute();
        step(16'hFFFF, 1'b0);
        step(16'hFFFF, 1'b1);
        step(16'h1234, 1'b0);
        step(16'h1234, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] tbl [6];
        tbl = '{16'h4000, 16'h8000, 16'h0002, 16'h0001, 16'hC000, 16'h7FFF};
        for (int i = 0; i < 6; i++) step(tbl[i], 1'b1);
        for (int i = 0; i < 3; i++) step(16'($urandom), 1'b1);
    endtask

    task automatic test_reset_mid();
        int n;
        drive_push(16'hFFFF, 1'b1);
        repeat (20 * 2 * BH) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({aud_bclk, aud_daclrck, aud_dacdat, sample_tick} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000",
                     {aud_bclk, aud_daclrck, aud_dacdat, sample_tick});
        end
        model_reset();
        push_frame(16'hFFFF, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        checks++;
        if (n !== 2 * BH) begin
            errors++;
            $display("FAIL midreset_first_frame: got %0d clk expected %0d", n, 2 * BH);
        end
        repeat (FRAME - 1) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL drain: got %0d words left expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame_shape();
        test_square_wave();
        test_mid_frame();
        test_mute();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
